// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: decodes the ID opcode and carries the control bundle
// through ID/EX, EX/MEM and MEM/WB with stall, flush, memory-wait and halt handling.
module pipe_ctrl_unit #(
  parameter int MEM_LATENCY = 1,
  parameter int HALT_DRAIN  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode_id,
  input  logic       valid_id,
  input  logic       stall_id,
  input  logic       flush_id,
  output logic       branch_id,
  output logic       reg_src_id,
  output logic [3:0] alu_op_ex,
  output logic       alu_src_ex,
  output logic       z_en_ex,
  output logic       nv_en_ex,
  output logic       valid_ex,
  output logic       mem_en_mem,
  output logic       mem_wr_mem,
  output logic       valid_mem,
  output logic       mem_busy,
  output logic       reg_write_wb,
  output logic       mem_to_reg_wb,
  output logic       pcs_wb,
  output logic       valid_wb,
  output logic       hold_fetch,
  output logic       halted
);
  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;
  localparam logic [3:0] OP_HLT    = 4'hF;
  localparam logic [3:0] WAIT_LOAD = 4'(MEM_LATENCY - 1);

  logic [1:0] state_reg;
  logic [3:0] wait_cnt_reg;

  logic mem_en_ex, mem_wr_ex, reg_write_ex, mem_to_reg_ex, pcs_ex, hlt_ex;
  logic reg_write_mem, mem_to_reg_mem, pcs_mem, hlt_mem;
  logic hlt_wb;

  logic dec_alu_src, dec_z_en, dec_nv_en, dec_mem_en, dec_mem_wr;
  logic dec_reg_write, dec_mem_to_reg, dec_pcs, dec_hlt;
  logic accept_id;

  always_comb begin
    dec_alu_src    = opcode_id inside {4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB};
    dec_z_en       = opcode_id inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6};
    dec_nv_en      = opcode_id inside {4'h0, 4'h1};
    dec_mem_en     = opcode_id inside {4'h8, 4'h9};
    dec_mem_wr     = (opcode_id == 4'h9);
    dec_reg_write  = !(opcode_id inside {4'h9, 4'hC, 4'hD, 4'hF});
    dec_mem_to_reg = (opcode_id == 4'h8);
    dec_pcs        = (opcode_id == 4'hE);
    dec_hlt        = (opcode_id == OP_HLT);
  end

  assign mem_busy   = (wait_cnt_reg != 4'd0);
  assign halted     = (state_reg == ST_HALTED);
  assign hold_fetch = stall_id | mem_busy | (state_reg != ST_RUN);
  assign branch_id  = valid_id & ((opcode_id == 4'hC) | (opcode_id == 4'hD));
  assign reg_src_id = valid_id & ((opcode_id == 4'hA) | (opcode_id == 4'hB));

  // A memory wait outranks flush/stall; the hazard unit re-asserts them afterwards.
  assign accept_id = valid_id & ~flush_id & ~stall_id & ~mem_busy & (state_reg == ST_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op_ex     <= 4'h0;
      alu_src_ex    <= 1'b0;
      z_en_ex       <= 1'b0;
      nv_en_ex      <= 1'b0;
      valid_ex      <= 1'b0;
      mem_en_ex     <= 1'b0;
      mem_wr_ex     <= 1'b0;
      reg_write_ex  <= 1'b0;
      mem_to_reg_ex <= 1'b0;
      pcs_ex        <= 1'b0;
      hlt_ex        <= 1'b0;
    end else if (!mem_busy) begin
      alu_op_ex     <= (accept_id && !dec_hlt) ? opcode_id : 4'h0;
      alu_src_ex    <= accept_id & dec_alu_src;
      z_en_ex       <= accept_id & dec_z_en;
      nv_en_ex      <= accept_id & dec_nv_en;
      valid_ex      <= accept_id;
      mem_en_ex     <= accept_id & dec_mem_en;
      mem_wr_ex     <= accept_id & dec_mem_wr;
      reg_write_ex  <= accept_id & dec_reg_write;
      mem_to_reg_ex <= accept_id & dec_mem_to_reg;
      pcs_ex        <= accept_id & dec_pcs;
      hlt_ex        <= accept_id & dec_hlt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en_mem     <= 1'b0;
      mem_wr_mem     <= 1'b0;
      valid_mem      <= 1'b0;
      reg_write_mem  <= 1'b0;
      mem_to_reg_mem <= 1'b0;
      pcs_mem        <= 1'b0;
      hlt_mem        <= 1'b0;
    end else if (!mem_busy) begin
      mem_en_mem     <= mem_en_ex;
      mem_wr_mem     <= mem_wr_ex;
      valid_mem      <= valid_ex;
      reg_write_mem  <= reg_write_ex;
      mem_to_reg_mem <= mem_to_reg_ex;
      pcs_mem        <= pcs_ex;
      hlt_mem        <= hlt_ex;
    end
  end

  // Counter loads as a memory op enters MEM, so it occupies MEM for MEM_LATENCY cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_reg <= 4'd0;
    end else if (mem_busy) begin
      wait_cnt_reg <= wait_cnt_reg - 4'd1;
    end else if (valid_ex && mem_en_ex) begin
      wait_cnt_reg <= WAIT_LOAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_wb  <= 1'b0;
      mem_to_reg_wb <= 1'b0;
      pcs_wb        <= 1'b0;
      valid_wb      <= 1'b0;
      hlt_wb        <= 1'b0;
    end else begin
      reg_write_wb  <= reg_write_mem & ~mem_busy;
      mem_to_reg_wb <= mem_to_reg_mem & ~mem_busy;
      pcs_wb        <= pcs_mem & ~mem_busy;
      valid_wb      <= valid_mem & ~mem_busy;
      hlt_wb        <= hlt_mem & ~mem_busy;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_RUN;
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (accept_id && dec_hlt) state_reg <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (HALT_DRAIN == 0 || (valid_wb && hlt_wb)) state_reg <= ST_HALTED;
        end
        default: state_reg <= ST_HALTED;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: three instances (latency 1/3/4, drain on/off/on) share
// stimulus; expectations are queued per cycle and compared when that cycle arrives.
module tb_pipe_ctrl_unit;
  localparam int N = 3;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam int F_EX = 0, F_MEM = 1, F_WB = 2, F_BUSY = 3, F_HOLD = 4;
  localparam int F_HALT = 5, F_BR = 6, F_RS = 7, F_VEX = 8, F_VWB = 9, F_ALL = 10;
  localparam int NV = 20;

  logic       clk;
  logic       rst_n;
  logic [3:0] opcode_id;
  logic       valid_id, stall_id, flush_id;

  logic       branch_id [N];
  logic       reg_src_id [N];
  logic [3:0] alu_op_ex [N];
  logic       alu_src_ex [N];
  logic       z_en_ex [N];
  logic       nv_en_ex [N];
  logic       valid_ex [N];
  logic       mem_en_mem [N];
  logic       mem_wr_mem [N];
  logic       valid_mem [N];
  logic       mem_busy [N];
  logic       reg_write_wb [N];
  logic       mem_to_reg_wb [N];
  logic       pcs_wb [N];
  logic       valid_wb [N];
  logic       hold_fetch [N];
  logic       halted [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    pipe_ctrl_unit #(
      .MEM_LATENCY(gi == 0 ? 1 : (gi == 1 ? 3 : 4)),
      .HALT_DRAIN (gi == 1 ? 0 : 1)
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .opcode_id    (opcode_id),
      .valid_id     (valid_id),
      .stall_id     (stall_id),
      .flush_id     (flush_id),
      .branch_id    (branch_id[gi]),
      .reg_src_id   (reg_src_id[gi]),
      .alu_op_ex    (alu_op_ex[gi]),
      .alu_src_ex   (alu_src_ex[gi]),
      .z_en_ex      (z_en_ex[gi]),
      .nv_en_ex     (nv_en_ex[gi]),
      .valid_ex     (valid_ex[gi]),
      .mem_en_mem   (mem_en_mem[gi]),
      .mem_wr_mem   (mem_wr_mem[gi]),
      .valid_mem    (valid_mem[gi]),
      .mem_busy     (mem_busy[gi]),
      .reg_write_wb (reg_write_wb[gi]),
      .mem_to_reg_wb(mem_to_reg_wb[gi]),
      .pcs_wb       (pcs_wb[gi]),
      .valid_wb     (valid_wb[gi]),
      .hold_fetch   (hold_fetch[gi]),
      .halted       (halted[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic v, st, fl, br, rs;
    logic [7:0] ex;
    logic [2:0] mem;
    logic [3:0] wb;
  } vec_t;

  typedef struct {
    int due;
    int dut;
    int field;
    logic [31:0] exp;
    string name;
  } exp_t;

  vec_t vecs [NV];
  exp_t sb [$];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  function automatic vec_t mk(input logic [3:0] op, input logic v, input logic st,
                              input logic fl, input logic br, input logic rs,
                              input logic [7:0] ex, input logic [2:0] mem, input logic [3:0] wb);
    vec_t r;
    r.op = op; r.v = v; r.st = st; r.fl = fl; r.br = br; r.rs = rs;
    r.ex = ex; r.mem = mem; r.wb = wb;
    return r;
  endfunction

  function automatic logic [31:0] obs(input int d, input int f);
    case (f)
      F_EX:   return {24'd0, alu_op_ex[d], alu_src_ex[d], z_en_ex[d], nv_en_ex[d], valid_ex[d]};
      F_MEM:  return {29'd0, mem_en_mem[d], mem_wr_mem[d], valid_mem[d]};
      F_WB:   return {28'd0, reg_write_wb[d], mem_to_reg_wb[d], pcs_wb[d], valid_wb[d]};
      F_BUSY: return {31'd0, mem_busy[d]};
      F_HOLD: return {31'd0, hold_fetch[d]};
      F_HALT: return {31'd0, halted[d]};
      F_BR:   return {31'd0, branch_id[d]};
      F_RS:   return {31'd0, reg_src_id[d]};
      F_VEX:  return {31'd0, valid_ex[d]};
      F_VWB:  return {31'd0, valid_wb[d]};
      F_ALL:  return {14'd0, alu_op_ex[d], alu_src_ex[d], z_en_ex[d], nv_en_ex[d], valid_ex[d],
                      mem_en_mem[d], mem_wr_mem[d], valid_mem[d],
                      reg_write_wb[d], mem_to_reg_wb[d], pcs_wb[d], valid_wb[d],
                      mem_busy[d], hold_fetch[d], halted[d]};
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", nm, d, cyc, act, exp);
    end else begin
      $display("ok   %s dut%0d cyc=%0d val=%h", nm, d, cyc, act);
    end
  endtask

  task automatic expect_at(input int due, input int d, input int f, input logic [31:0] e,
                           input string nm);
    exp_t x;
    x.due = due; x.dut = d; x.field = f; x.exp = e; x.name = nm;
    sb.push_back(x);
  endtask

  task automatic check_due();
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        chk(sb[i].name, sb[i].dut, obs(sb[i].dut, sb[i].field), sb[i].exp);
        sb.delete(i);
      end
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic v, input logic st, input logic fl);
    opcode_id = op;
    valid_id  = v;
    stall_id  = st;
    flush_id  = fl;
  endtask

  task automatic cycle_end();
    #1;
    check_due();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    drive(4'h0, L, L, L);
    for (int n = 0; n < 60 && sb.size() != 0; n++) cycle_end();
    foreach (sb[i]) begin
      total++;
      bad++;
      $display("FAIL %s dut%0d never checked (due cyc=%0d)", sb[i].name, sb[i].dut, sb[i].due);
    end
    sb.delete();
  endtask

  task automatic do_reset();
    sb.delete();
    drive(4'h0, L, L, L);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < N; d++) chk("reset_all", d, obs(d, F_ALL), 32'd0);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(4'h0, L, L, L);

    // {op, valid, stall, flush, branch, reg_src, EX bundle, MEM bundle, WB bundle}
    vecs[0]  = mk(4'h0, H, L, L, L, L, 8'b0000_0111, 3'b001, 4'b1001);
    vecs[1]  = mk(4'h1, H, L, L, L, L, 8'b0001_0111, 3'b001, 4'b1001);
    vecs[2]  = mk(4'h2, H, L, L, L, L, 8'b0010_0101, 3'b001, 4'b1001);
    vecs[3]  = mk(4'h3, H, L, L, L, L, 8'b0011_0001, 3'b001, 4'b1001);
    vecs[4]  = mk(4'h4, H, L, L, L, L, 8'b0100_1101, 3'b001, 4'b1001);
    vecs[5]  = mk(4'h5, H, L, L, L, L, 8'b0101_1101, 3'b001, 4'b1001);
    vecs[6]  = mk(4'h6, H, L, L, L, L, 8'b0110_1101, 3'b001, 4'b1001);
    vecs[7]  = mk(4'h7, H, L, L, L, L, 8'b0111_0001, 3'b001, 4'b1001);
    vecs[8]  = mk(4'h8, H, L, L, L, L, 8'b1000_1001, 3'b101, 4'b1101);
    vecs[9]  = mk(4'h9, H, L, L, L, L, 8'b1001_1001, 3'b111, 4'b0001);
    vecs[10] = mk(4'hA, H, L, L, L, H, 8'b1010_1001, 3'b001, 4'b1001);
    vecs[11] = mk(4'hB, H, L, L, L, H, 8'b1011_1001, 3'b001, 4'b1001);
    vecs[12] = mk(4'hC, H, L, L, H, L, 8'b1100_0001, 3'b001, 4'b0001);
    vecs[13] = mk(4'hD, H, L, L, H, L, 8'b1101_0001, 3'b001, 4'b0001);
    vecs[14] = mk(4'hE, H, L, L, L, L, 8'b1110_0001, 3'b001, 4'b1011);
    vecs[15] = mk(4'hC, L, L, L, L, L, 8'h00, 3'b000, 4'b0000);
    vecs[16] = mk(4'h1, H, H, L, L, L, 8'h00, 3'b000, 4'b0000);
    vecs[17] = mk(4'h1, H, L, L, L, L, 8'b0001_0111, 3'b001, 4'b1001);
    vecs[18] = mk(4'h1, H, H, H, L, L, 8'h00, 3'b000, 4'b0000);
    vecs[19] = mk(4'hA, H, L, H, L, H, 8'h00, 3'b000, 4'b0000);

    // Table: one instruction per cycle on the latency-1 instance.
    do_reset();
    for (int k = 0; k < NV; k++) begin
      drive(vecs[k].op, vecs[k].v, vecs[k].st, vecs[k].fl);
      expect_at(k, 0, F_BR, {31'd0, vecs[k].br}, $sformatf("tbl%0d_branch", k));
      expect_at(k, 0, F_RS, {31'd0, vecs[k].rs}, $sformatf("tbl%0d_regsrc", k));
      expect_at(k, 0, F_HOLD, {31'd0, vecs[k].st}, $sformatf("tbl%0d_hold", k));
      expect_at(k + 1, 0, F_EX, {24'd0, vecs[k].ex}, $sformatf("tbl%0d_ex", k));
      expect_at(k + 2, 0, F_MEM, {29'd0, vecs[k].mem}, $sformatf("tbl%0d_mem", k));
      expect_at(k + 3, 0, F_WB, {28'd0, vecs[k].wb}, $sformatf("tbl%0d_wb", k));
      cycle_end();
    end
    drain();

    // LW then ADD: latency 3 and 4 waits.
    do_reset();
    for (int c = 2; c <= 3; c++) begin
      expect_at(c, 1, F_BUSY, 1, "lw_busy");
      expect_at(c, 1, F_HOLD, 1, "lw_hold");
    end
    for (int c = 2; c <= 4; c++) begin
      expect_at(c, 1, F_VWB, 0, "lw_wait_vwb");
      expect_at(c, 1, F_MEM, 3'b101, "lw_in_mem");
      expect_at(c, 1, F_EX, 8'b0000_0111, "add_held_ex");
      expect_at(c, 2, F_BUSY, 1, "lw4_busy");
    end
    expect_at(4, 1, F_BUSY, 0, "lw_busy_end");
    expect_at(4, 1, F_HOLD, 0, "lw_hold_end");
    expect_at(5, 1, F_WB, 4'b1101, "lw_wb");
    expect_at(6, 1, F_WB, 4'b1001, "add_wb");
    expect_at(5, 2, F_BUSY, 0, "lw4_busy_end");
    expect_at(6, 2, F_WB, 4'b1101, "lw4_wb");
    expect_at(7, 2, F_WB, 4'b1001, "add4_wb");
    expect_at(3, 0, F_WB, 4'b1101, "lw1_wb");
    expect_at(4, 0, F_WB, 4'b1001, "add1_wb");
    expect_at(2, 0, F_BUSY, 0, "lw1_never_busy");
    drive(4'h8, H, L, L); cycle_end();
    drive(4'h0, H, L, L); cycle_end();
    drain();

    // Back-to-back LW, SW on latency 3: each waits fully.
    do_reset();
    expect_at(5, 1, F_WB, 4'b1101, "b2b_lw_wb");
    expect_at(5, 1, F_MEM, 3'b111, "b2b_sw_mem");
    expect_at(5, 1, F_BUSY, 1, "b2b_sw_busy");
    expect_at(6, 1, F_BUSY, 1, "b2b_sw_busy");
    expect_at(7, 1, F_BUSY, 0, "b2b_sw_busy_end");
    expect_at(7, 1, F_HOLD, 0, "b2b_hold_end");
    expect_at(6, 1, F_VWB, 0, "b2b_wait_vwb");
    expect_at(7, 1, F_VWB, 0, "b2b_wait_vwb");
    expect_at(8, 1, F_WB, 4'b0001, "b2b_sw_wb");
    drive(4'h8, H, L, L); cycle_end();
    drive(4'h9, H, L, L); cycle_end();
    drain();

    // SW then HLT, then an ADD that must be bubbled while draining.
    do_reset();
    expect_at(1, 0, F_HOLD, 0, "hlt_hold_before");
    expect_at(2, 0, F_HOLD, 1, "hlt_hold_drain");
    expect_at(2, 0, F_MEM, 3'b111, "hlt_sw_mem");
    expect_at(2, 0, F_VEX, 1, "hlt_in_ex");
    expect_at(3, 0, F_EX, 8'h00, "drain_bubble_ex");
    expect_at(4, 0, F_WB, 4'b0001, "hlt_wb_bundle");
    expect_at(4, 0, F_HALT, 0, "hlt_not_yet");
    for (int c = 5; c <= 15; c++) expect_at(c, 0, F_HALT, 1, "hlt_sticky");
    expect_at(2, 1, F_HALT, 0, "nodrain_not_yet");
    expect_at(2, 1, F_HOLD, 1, "nodrain_hold");
    expect_at(3, 1, F_HALT, 1, "nodrain_halted");
    expect_at(7, 2, F_HALT, 0, "lat4_hlt_not_yet");
    expect_at(8, 2, F_HALT, 1, "lat4_hlt_halted");
    expect_at(4, 2, F_BUSY, 1, "lat4_sw_busy");
    expect_at(5, 2, F_BUSY, 0, "lat4_sw_busy_end");
    drive(4'h9, H, L, L); cycle_end();
    drive(4'hF, H, L, L); cycle_end();
    drive(4'h0, H, L, L); cycle_end();
    drain();

    // Flushed HLT, then stalled HLT: neither may start the drain.
    do_reset();
    expect_at(0, 0, F_HOLD, 0, "flush_hlt_hold");
    expect_at(1, 0, F_VEX, 0, "flush_hlt_vex");
    expect_at(1, 0, F_HALT, 0, "flush_hlt_halt");
    expect_at(1, 0, F_HOLD, 0, "flush_hlt_run");
    expect_at(2, 0, F_HOLD, 1, "stall_hlt_hold");
    expect_at(3, 0, F_HOLD, 0, "stall_hlt_run");
    expect_at(3, 0, F_VEX, 0, "stall_hlt_vex");
    expect_at(3, 1, F_HALT, 0, "flush_hlt_nodrain");
    expect_at(5, 1, F_HALT, 0, "stall_hlt_nodrain");
    expect_at(6, 0, F_HALT, 0, "stall_hlt_halt");
    drive(4'hF, H, L, H); cycle_end();
    drive(4'h0, L, L, L); cycle_end();
    drive(4'hF, H, H, L); cycle_end();
    drain();

    // Asynchronous reset in the middle of a latency-4 wait.
    do_reset();
    expect_at(2, 2, F_BUSY, 1, "rstw_busy");
    drive(4'h8, H, L, L); cycle_end();
    drive(4'h0, L, L, L); cycle_end();
    cycle_end();
    chk("rstw_pre_busy", 2, obs(2, F_BUSY), 32'd1);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < N; d++) chk("rstw_async_all", d, obs(d, F_ALL), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    sb.delete();
    expect_at(0, 2, F_BUSY, 0, "rstw_after_busy");
    expect_at(0, 2, F_HOLD, 0, "rstw_after_run");
    expect_at(1, 2, F_EX, 8'b0000_0111, "rstw_add_ex");
    expect_at(3, 2, F_WB, 4'b1001, "rstw_add_wb");
    expect_at(3, 2, F_HALT, 0, "rstw_halt");
    drive(4'h0, H, L, L); cycle_end();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
